fetch_pc: RTL

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc_pkg.sv | 22 ++
 rtl/fetch_npc.sv | 33 +++
 rtl/fetch_pc.sv | 80 ++++++++
 3 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared constants and types for the instruction-fetch PC stage.
package fetch_pc_pkg;

   // Address map of the instruction stream
   localparam logic [31:0] RESET_VEC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;
   localparam logic [31:0] TEXT_LO     = 32'h0000_3000;
   localparam logic [31:0] TEXT_HI     = 32'h0000_6FFC;

   // Exception codes reported by the fetch stage
   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   // Next-PC source selected by the decode stage
   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC mux: sequential, branch, jump and jump-register targets.
module fetch_npc
   import fetch_pc_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic [31:0] j_target,
   input  logic [31:0] jr_target,
   output logic [31:0] npc
);

   logic [31:0] pc_plus4;
   npc_sel_e    sel;

   // Wraps naturally from 0xFFFF_FFFC to 0x0 in 32-bit arithmetic.
   assign pc_plus4 = pc + 32'd4;
   assign sel      = npc_sel_e'(npc_sel);

   // Pick the next fetch address from the decode-stage redirect sources
   always_comb begin
      // NOTE: default assignment first so no path leaves npc unassigned (no latch).
      npc = pc_plus4;
      case (sel)
         NPC_SEQ: npc = pc_plus4;
         NPC_BR:  npc = br_taken ? br_target : pc_plus4;
         NPC_J:   npc = j_target;
         NPC_JR:  npc = jr_target;
      endcase
   end

endmodule

// File: rtl/fetch_pc.sv
// Fetch-stage program counter with exception/eret redirect and fetch AdEL check.
// Optional feature macro: FETCH_ADEL_CHECK_EN (enables the address-error check).
module fetch_pc
   import fetch_pc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        Req,
   input  logic        Eret,
   input  logic [31:0] EPC,
   input  logic [1:0]  npc_sel,
   input  logic [31:0] br_target,
   input  logic [31:0] j_target,
   input  logic [31:0] jr_target,
   input  logic        br_taken,
   input  logic        ctrl_D,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] PC8,
   output logic [31:0] instr,
   output logic [4:0]  Excode_F,
   output logic        BD
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] npc;

   fetch_npc u_npc (
      .pc        (pc_q),
      .npc_sel   (npc_sel),
      .br_taken  (br_taken),
      .br_target (br_target),
      .j_target  (j_target),
      .jr_target (jr_target),
      .npc       (npc)
   );

   // Redirect priority: exception request, then eret, then stall, then normal flow
   always_comb begin
      pc_d = npc;
      if (Req) begin
         pc_d = HANDLER_VEC;
      end else if (Eret) begin
         pc_d = EPC;
      end else if (!en) begin
         pc_d = pc_q;
      end
   end

   // PC register; reset loads the boot vector asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_VEC;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         pc_q <= pc_d;
      end
   end

   assign PC  = pc_q;
   assign PC8 = pc_q + 32'd8;

   // A redirect flushes the slot, so the delay-slot flag is cleared with it.
   assign BD = ctrl_D & ~Req & ~Eret;

`ifdef FETCH_ADEL_CHECK_EN
   logic adel;

   // Address error is re-derived from the current PC every cycle; nothing is latched.
   assign adel     = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
   assign Excode_F = adel ? EXC_ADEL : EXC_NONE;
   assign instr    = adel ? 32'h0 : imem_rdata;
`else
   assign Excode_F = EXC_NONE;
   assign instr    = imem_rdata;
`endif

endmodule
